// File: rtl/ariane_pkg.sv
// Shared definitions for the divider issue controller: functional-unit opcodes,
// transaction id width, divider opcode encoding and FSM state encoding.
package ariane_pkg;

  localparam int TRANS_ID_BITS = 3;

  typedef enum logic [3:0] {
    ADD   = 4'd0,
    DIV   = 4'd1,
    DIVU  = 4'd2,
    REM   = 4'd3,
    REMU  = 4'd4,
    DIVW  = 4'd5,
    DIVUW = 4'd6,
    REMW  = 4'd7,
    REMUW = 4'd8
  } fu_op;

  localparam logic [1:0] DIV_OP_UDIV = 2'd0;
  localparam logic [1:0] DIV_OP_DIV  = 2'd1;
  localparam logic [1:0] DIV_OP_UREM = 2'd2;
  localparam logic [1:0] DIV_OP_REM  = 2'd3;

  typedef logic [1:0] div_state_t;
  localparam div_state_t ST_IDLE = 2'd0;
  localparam div_state_t ST_BUSY = 2'd1;
  localparam div_state_t ST_RESP = 2'd2;

endpackage

// File: rtl/div_issue_ctrl_if.sv
// Issue, divider and writeback signals of the divider issue controller.
// The slave modport is the controller's view; master is the surrounding pipeline.
interface div_issue_ctrl_if #(parameter int WIDTH = 64);

  logic                                 flush_i;
  logic                                 valid_i;
  logic                                 ready_o;
  ariane_pkg::fu_op                     operation_i;
  logic [ariane_pkg::TRANS_ID_BITS-1:0] trans_id_i;
  logic [WIDTH-1:0]                     op_a_i;
  logic [WIDTH-1:0]                     op_b_i;

  logic                                 div_in_vld_o;
  logic                                 div_in_rdy_i;
  logic [ariane_pkg::TRANS_ID_BITS-1:0] div_id_o;
  logic [WIDTH-1:0]                     div_op_a_o;
  logic [WIDTH-1:0]                     div_op_b_o;
  logic [1:0]                           div_opcode_o;
  logic                                 div_flush_o;
  logic                                 div_out_vld_i;
  logic                                 div_out_rdy_o;
  logic [ariane_pkg::TRANS_ID_BITS-1:0] div_id_i;
  logic [WIDTH-1:0]                     div_res_i;

  logic                                 valid_o;
  logic                                 wb_ready_i;
  logic [ariane_pkg::TRANS_ID_BITS-1:0] trans_id_o;
  logic [WIDTH-1:0]                     result_o;

  modport slave (
    input  flush_i, valid_i, operation_i, trans_id_i, op_a_i, op_b_i,
           div_in_rdy_i, div_out_vld_i, div_id_i, div_res_i, wb_ready_i,
    output ready_o, div_in_vld_o, div_id_o, div_op_a_o, div_op_b_o, div_opcode_o,
           div_flush_o, div_out_rdy_o, valid_o, trans_id_o, result_o
  );

  modport master (
    output flush_i, valid_i, operation_i, trans_id_i, op_a_i, op_b_i,
           div_in_rdy_i, div_out_vld_i, div_id_i, div_res_i, wb_ready_i,
    input  ready_o, div_in_vld_o, div_id_o, div_op_a_o, div_op_b_o, div_opcode_o,
           div_flush_o, div_out_rdy_o, valid_o, trans_id_o, result_o
  );

endinterface

// File: rtl/div_issue_ctrl_operand_prep.sv
// Combinational decode of the fu_op into divider opcode and word flag, plus
// 32-bit operand extension for the W variants.
module div_operand_prep
  import ariane_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  fu_op             operation,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] op_a_prep,
  output logic [WIDTH-1:0] op_b_prep,
  output logic [1:0]       opcode,
  output logic             is_word,
  output logic             is_div
);

  logic is_rem;
  logic is_signed;

  always_comb begin
    is_div    = 1'b1;
    is_word   = 1'b0;
    is_rem    = 1'b0;
    is_signed = 1'b0;
    case (operation)
      DIV:     is_signed = 1'b1;
      DIVU:    ;
      REM:     begin is_rem = 1'b1; is_signed = 1'b1; end
      REMU:    is_rem = 1'b1;
      DIVW:    begin is_word = 1'b1; is_signed = 1'b1; end
      DIVUW:   is_word = 1'b1;
      REMW:    begin is_word = 1'b1; is_rem = 1'b1; is_signed = 1'b1; end
      REMUW:   begin is_word = 1'b1; is_rem = 1'b1; end
      default: is_div = 1'b0;
    endcase
  end

  assign op_a_prep = is_word ? {{(WIDTH-32){is_signed & op_a[31]}}, op_a[31:0]} : op_a;
  assign op_b_prep = is_word ? {{(WIDTH-32){is_signed & op_b[31]}}, op_b[31:0]} : op_b;
  assign opcode    = {is_rem, is_signed};

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue-side controller for the serial divider: one request in flight, result
// held for writeback under backpressure. Optional feature macro: DIV_ZERO_FASTPATH_EN.
//
// state   | meaning
// IDLE    | waiting for a request; handshake to divider is combinational
// BUSY    | request accepted by divider, waiting for the matching response
// RESP    | result held, valid_o high until writeback accepts it
module div_issue_ctrl
  import ariane_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input logic             clk_i,
  input logic             rst_ni,
  div_issue_ctrl_if.slave bus
);

  logic [WIDTH-1:0]         op_a_prep;
  logic [WIDTH-1:0]         op_b_prep;
  logic [1:0]               opcode;
  logic                     is_word;
  logic                     is_div;

  div_state_t               state_q;
  div_state_t               state_d;
  logic [TRANS_ID_BITS-1:0] id_q;
  logic                     is_word_q;
  logic [WIDTH-1:0]         result_q;

  logic                     req_fire;
  logic                     resp_fire;
  logic                     zero_div;

  div_operand_prep #(.WIDTH(WIDTH)) u_prep (
    .operation (bus.operation_i),
    .op_a      (bus.op_a_i),
    .op_b      (bus.op_b_i),
    .op_a_prep (op_a_prep),
    .op_b_prep (op_b_prep),
    .opcode    (opcode),
    .is_word   (is_word),
    .is_div    (is_div)
  );

  function automatic logic [WIDTH-1:0] fmt_res(input logic [WIDTH-1:0] r, input logic w);
    return w ? {{(WIDTH-32){r[31]}}, r[31:0]} : r;
  endfunction

`ifdef DIV_ZERO_FASTPATH_EN
  logic [WIDTH-1:0] zero_res;
  assign zero_div = (op_b_prep == '0);
  // Divide-by-zero is answered locally with the architectural results.
  assign zero_res = opcode[1] ? op_a_prep : '1;
`else
  assign zero_div = 1'b0;
`endif

  assign req_fire  = (state_q == ST_IDLE) & bus.valid_i & is_div & ~bus.flush_i;
  assign resp_fire = (state_q == ST_BUSY) & bus.div_out_vld_i & (bus.div_id_i == id_q)
                     & ~bus.flush_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_fire) state_d = zero_div ? ST_RESP : ST_BUSY;
      ST_BUSY: if (resp_fire) state_d = ST_RESP;
      ST_RESP: if (bus.wb_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (bus.flush_i) state_d = ST_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      id_q      <= '0;
      is_word_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q <= state_d;
      if (req_fire) begin
        id_q      <= bus.trans_id_i;
        is_word_q <= is_word;
      end
      if (resp_fire) result_q <= fmt_res(bus.div_res_i, is_word_q);
`ifdef DIV_ZERO_FASTPATH_EN
      if (req_fire && zero_div) result_q <= fmt_res(zero_res, is_word);
`endif
    end
  end

  assign bus.ready_o       = (state_q == ST_IDLE) & bus.div_in_rdy_i & ~bus.flush_i;
  assign bus.div_in_vld_o  = req_fire & ~zero_div;
  assign bus.div_id_o      = bus.trans_id_i;
  assign bus.div_op_a_o    = op_a_prep;
  assign bus.div_op_b_o    = op_b_prep;
  assign bus.div_opcode_o  = opcode;
  assign bus.div_flush_o   = bus.flush_i;
  assign bus.div_out_rdy_o = (state_q == ST_BUSY);
  assign bus.valid_o       = (state_q == ST_RESP);
  assign bus.trans_id_o    = id_q;
  assign bus.result_o      = result_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl; the bench plays the issue stage, the divider
// and writeback, with hand-computed expected values.
module tb_div_issue_ctrl;
  import ariane_pkg::*;

  localparam int W = 64;

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  div_issue_ctrl_if #(.WIDTH(W)) bus();

  div_issue_ctrl #(.WIDTH(W)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic issue(input string name, input fu_op op, input logic [2:0] id,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] ea, input logic [63:0] eb,
                       input logic [1:0] eopc, input logic evld);
    bus.valid_i     = 1'b1;
    bus.operation_i = op;
    bus.trans_id_i  = id;
    bus.op_a_i      = a;
    bus.op_b_i      = b;
    #1;
    chk({name, ".in_vld"}, 64'(bus.div_in_vld_o), 64'(evld));
    if (evld) begin
      chk({name, ".op_a"}, bus.div_op_a_o, ea);
      chk({name, ".op_b"}, bus.div_op_b_o, eb);
      chk({name, ".opcode"}, 64'(bus.div_opcode_o), 64'(eopc));
      chk({name, ".div_id"}, 64'(bus.div_id_o), 64'(id));
    end
    @(negedge clk_i);
    bus.valid_i     = 1'b0;
    bus.operation_i = ADD;
  endtask

  task automatic respond(input logic [2:0] id, input logic [63:0] res);
    bus.div_out_vld_i = 1'b1;
    bus.div_id_i      = id;
    bus.div_res_i     = res;
    @(negedge clk_i);
    bus.div_out_vld_i = 1'b0;
  endtask

  task automatic expect_wb(input string name, input logic [2:0] id, input logic [63:0] res);
    #1;
    chk({name, ".valid"}, 64'(bus.valid_o), 64'd1);
    chk({name, ".result"}, bus.result_o, res);
    chk({name, ".trans_id"}, 64'(bus.trans_id_o), 64'(id));
    chk({name, ".ready_resp"}, 64'(bus.ready_o), 64'd0);
    bus.wb_ready_i = 1'b1;
    @(negedge clk_i);
    bus.wb_ready_i = 1'b0;
    #1;
    chk({name, ".valid_after"}, 64'(bus.valid_o), 64'd0);
    chk({name, ".ready_after"}, 64'(bus.ready_o), 64'd1);
  endtask

  initial begin
    rst_ni            = 1'b0;
    bus.flush_i       = 1'b0;
    bus.valid_i       = 1'b0;
    bus.operation_i   = ADD;
    bus.trans_id_i    = '0;
    bus.op_a_i        = '0;
    bus.op_b_i        = '0;
    bus.div_in_rdy_i  = 1'b1;
    bus.div_out_vld_i = 1'b0;
    bus.div_id_i      = '0;
    bus.div_res_i     = '0;
    bus.wb_ready_i    = 1'b0;

    @(negedge clk_i);
    #1;
    chk("rst.valid", 64'(bus.valid_o), 64'd0);
    chk("rst.result", bus.result_o, 64'd0);
    chk("rst.trans_id", 64'(bus.trans_id_o), 64'd0);
    chk("rst.in_vld", 64'(bus.div_in_vld_o), 64'd0);
    chk("rst.out_rdy", 64'(bus.div_out_rdy_o), 64'd0);
    chk("rst.flush", 64'(bus.div_flush_o), 64'd0);
    chk("rst.ready_hi", 64'(bus.ready_o), 64'd1);
    bus.div_in_rdy_i = 1'b0;
    #1;
    chk("rst.ready_lo", 64'(bus.ready_o), 64'd0);
    bus.div_in_rdy_i = 1'b1;
    @(negedge clk_i);
    rst_ni = 1'b1;

    // DIV -7/2 with a mismatching response dropped first
    issue("div", DIV, 3'd3, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
          64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 2'd1, 1'b1);
    #1;
    chk("div.busy_ready", 64'(bus.ready_o), 64'd0);
    chk("div.busy_out_rdy", 64'(bus.div_out_rdy_o), 64'd1);
    respond(3'd5, 64'd99);
    #1;
    chk("div.drop_valid", 64'(bus.valid_o), 64'd0);
    chk("div.drop_out_rdy", 64'(bus.div_out_rdy_o), 64'd1);
    respond(3'd3, 64'hFFFF_FFFF_FFFF_FFFD);
    expect_wb("div", 3'd3, 64'hFFFF_FFFF_FFFF_FFFD);

    issue("divuw", DIVUW, 3'd1, 64'hFFFF_FFFF_8000_0000, 64'd2,
          64'h0000_0000_8000_0000, 64'd2, 2'd0, 1'b1);
    respond(3'd1, 64'h0000_0000_4000_0000);
    expect_wb("divuw", 3'd1, 64'h0000_0000_4000_0000);

    // DIVUW result with bit 31 set is still sign-extended on writeback
    issue("divuw_hi", DIVUW, 3'd7, 64'h1234_5678_FFFF_FFFF, 64'd1,
          64'h0000_0000_FFFF_FFFF, 64'd1, 2'd0, 1'b1);
    respond(3'd7, 64'h0000_0000_FFFF_FFFF);
    expect_wb("divuw_hi", 3'd7, 64'hFFFF_FFFF_FFFF_FFFF);

    issue("remw", REMW, 3'd2, 64'h0000_0000_FFFF_FFF9, 64'd2,
          64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 2'd3, 1'b1);
    respond(3'd2, 64'h0000_0000_FFFF_FFFF);
    expect_wb("remw", 3'd2, 64'hFFFF_FFFF_FFFF_FFFF);

    // flush in BUSY, stale response, then a clean DIVU 10/3
    issue("fl_busy", DIVU, 3'd4, 64'd10, 64'd3, 64'd10, 64'd3, 2'd0, 1'b1);
    bus.flush_i = 1'b1;
    #1;
    chk("fl_busy.div_flush", 64'(bus.div_flush_o), 64'd1);
    chk("fl_busy.ready", 64'(bus.ready_o), 64'd0);
    @(negedge clk_i);
    bus.flush_i = 1'b0;
    #1;
    chk("fl_busy.idle_out_rdy", 64'(bus.div_out_rdy_o), 64'd0);
    chk("fl_busy.idle_ready", 64'(bus.ready_o), 64'd1);
    respond(3'd4, 64'd123);
    #1;
    chk("fl_busy.stale_valid", 64'(bus.valid_o), 64'd0);
    chk("fl_busy.stale_out_rdy", 64'(bus.div_out_rdy_o), 64'd0);
    issue("divu", DIVU, 3'd6, 64'd10, 64'd3, 64'd10, 64'd3, 2'd0, 1'b1);
    respond(3'd6, 64'd3);
    expect_wb("divu", 3'd6, 64'd3);

    // writeback backpressure for 5 cycles
    issue("bp", REMU, 3'd5, 64'd100, 64'd7, 64'd100, 64'd7, 2'd2, 1'b1);
    respond(3'd5, 64'd2);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp.valid", 64'(bus.valid_o), 64'd1);
      chk("bp.result", bus.result_o, 64'd2);
      chk("bp.trans_id", 64'(bus.trans_id_o), 64'd5);
      chk("bp.ready", 64'(bus.ready_o), 64'd0);
      @(negedge clk_i);
    end
    expect_wb("bp", 3'd5, 64'd2);

    // flush together with a request in IDLE
    bus.flush_i     = 1'b1;
    bus.valid_i     = 1'b1;
    bus.operation_i = DIV;
    bus.op_a_i      = 64'd8;
    bus.op_b_i      = 64'd2;
    #1;
    chk("fl_idle.in_vld", 64'(bus.div_in_vld_o), 64'd0);
    chk("fl_idle.ready", 64'(bus.ready_o), 64'd0);
    chk("fl_idle.div_flush", 64'(bus.div_flush_o), 64'd1);
    @(negedge clk_i);
    bus.flush_i     = 1'b0;
    bus.valid_i     = 1'b0;
    bus.operation_i = ADD;
    #1;
    chk("fl_idle.out_rdy", 64'(bus.div_out_rdy_o), 64'd0);
    chk("fl_idle.valid", 64'(bus.valid_o), 64'd0);

    issue("bad_op", ADD, 3'd1, 64'd5, 64'd5, 64'd0, 64'd0, 2'd0, 1'b0);
    #1;
    chk("bad_op.out_rdy", 64'(bus.div_out_rdy_o), 64'd0);
    chk("bad_op.ready", 64'(bus.ready_o), 64'd1);

    // flush and matching response in the same BUSY cycle: flush wins
    issue("fl_resp", DIV, 3'd2, 64'd20, 64'd4, 64'd20, 64'd4, 2'd1, 1'b1);
    bus.flush_i       = 1'b1;
    bus.div_out_vld_i = 1'b1;
    bus.div_id_i      = 3'd2;
    bus.div_res_i     = 64'd5;
    @(negedge clk_i);
    bus.flush_i       = 1'b0;
    bus.div_out_vld_i = 1'b0;
    #1;
    chk("fl_resp.valid", 64'(bus.valid_o), 64'd0);
    chk("fl_resp.out_rdy", 64'(bus.div_out_rdy_o), 64'd0);
    chk("fl_resp.result_kept", bus.result_o, 64'd2);

    // flush and wb_ready together in RESP: single writeback, back to IDLE
    issue("fl_wb", DIV, 3'd1, 64'hFFFF_FFFF_FFFF_FFEC, 64'd4,
          64'hFFFF_FFFF_FFFF_FFEC, 64'd4, 2'd1, 1'b1);
    respond(3'd1, 64'hFFFF_FFFF_FFFF_FFFB);
    #1;
    chk("fl_wb.valid", 64'(bus.valid_o), 64'd1);
    chk("fl_wb.result", bus.result_o, 64'hFFFF_FFFF_FFFF_FFFB);
    bus.flush_i    = 1'b1;
    bus.wb_ready_i = 1'b1;
    @(negedge clk_i);
    bus.flush_i    = 1'b0;
    bus.wb_ready_i = 1'b0;
    #1;
    chk("fl_wb.valid_after", 64'(bus.valid_o), 64'd0);
    chk("fl_wb.ready_after", 64'(bus.ready_o), 64'd1);
    chk("fl_wb.out_rdy", 64'(bus.div_out_rdy_o), 64'd0);

`ifdef DIV_ZERO_FASTPATH_EN
    issue("zrem", REM, 3'd3, 64'd5, 64'd0, 64'd5, 64'd0, 2'd3, 1'b0);
    expect_wb("zrem", 3'd3, 64'd5);
    issue("zdivu", DIVU, 3'd4, 64'd5, 64'd0, 64'd5, 64'd0, 2'd0, 1'b0);
    expect_wb("zdivu", 3'd4, 64'hFFFF_FFFF_FFFF_FFFF);
`else
    issue("zdivu", DIVU, 3'd4, 64'd5, 64'd0, 64'd5, 64'd0, 2'd0, 1'b1);
    #1;
    chk("zdivu.out_rdy", 64'(bus.div_out_rdy_o), 64'd1);
    respond(3'd4, 64'hFFFF_FFFF_FFFF_FFFF);
    expect_wb("zdivu", 3'd4, 64'hFFFF_FFFF_FFFF_FFFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/div_issue_ctrl.md
# div_issue_ctrl

Initiator-side controller for the serial divider functional unit. Accepts divide/remainder requests from the issue stage, prepares RV64 operands (including 32-bit W variants), drives the divider's request handshake, collects the divider result into a holding register and presents it to writeback with backpressure. Sits between issue/read-operands and `serdiv`, inside the mult/div functional-unit wrapper.

## Interface
- `WIDTH`, 64, datapath width; W ops use the low 32 bits.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `flush_i` in 1: pipeline flush.
- `valid_i` in 1: request valid. It arrives one cycle after `ready_o` was high.
- `ready_o` out 1: controller can accept.
- `operation_i` in fu_op: one of DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW.
- `trans_id_i` in TRANS_ID_BITS: transaction id.
- `op_a_i`, `op_b_i` in WIDTH: dividend, divisor.
- `div_in_vld_o` out 1, `div_in_rdy_i` in 1: request handshake to the divider.
- `div_id_o` out TRANS_ID_BITS, `div_op_a_o`, `div_op_b_o` out WIDTH, `div_opcode_o` out 2: request payload. Opcode is 0 udiv, 1 div, 2 urem, 3 rem.
- `div_flush_o` out 1: flush forwarded to the divider.
- `div_out_vld_i` in 1, `div_out_rdy_o` out 1, `div_id_i` in TRANS_ID_BITS, `div_res_i` in WIDTH: divider response.
- `valid_o` out 1, `wb_ready_i` in 1, `trans_id_o` out TRANS_ID_BITS, `result_o` out WIDTH: writeback.

## Operation
- FSM states:
  - IDLE: `ready_o = div_in_rdy_i`. On `valid_i`:
    - Drive `div_in_vld_o=1` combinationally with the prepared operands.
    - Latch `trans_id_i` and the `is_word` flag.
    - Go to BUSY.
  - BUSY: `div_out_rdy_o=1`. On `div_out_vld_i` with `div_id_i == id_q`:
    - Load the result register.
    - Go to RESP.
    - A response with a mismatching id is accepted and dropped.
  - RESP: `valid_o=1`. On `wb_ready_i`, go to IDLE. `ready_o=0` while in RESP.
- Operand prep for W ops:
  - Signed ops (DIVW, REMW): sign-extend `op[31:0]`.
  - Unsigned ops (DIVUW, REMUW): zero-extend `op[31:0]`.
  - Non-W ops pass through unchanged.
- Opcode encoding: `div_opcode_o = {is_rem, is_signed}`.
- Result formatting: for W ops, `result = sext(div_res_i[31:0])`, including DIVUW and REMUW. Otherwise `div_res_i` is used unchanged. Formatting is applied when the result register is loaded.
- Flush:
  - Asserting `flush_i` in any state forces IDLE.
  - It also clears `valid_o` (from the next cycle) and asserts `div_flush_o` the same cycle.
  - `ready_o` and `div_in_vld_o` are 0 while `flush_i` is asserted.
- An operation other than the eight listed is ignored; the FSM stays in IDLE.
- Reset: state IDLE, `valid_o=0`, `result_o=0`, `trans_id_o=0`, `div_in_vld_o=0`, `div_out_rdy_o=0`, `div_flush_o=0`. `ready_o` follows `div_in_rdy_i`.

## Timing
- Request cycle: `div_in_vld_o` is asserted in the same cycle `valid_i` is seen in IDLE, with zero added latency.
- Response: `valid_o` rises in the cycle after the divider handshake completes (`div_out_vld_i` and `div_out_rdy_o`).
- Outstanding requests: at most one in flight. There is no new request until RESP completes.
- Backpressure: while `wb_ready_i=0`, `result_o` and `trans_id_o` are held stable.
- Simultaneous `flush_i` and `div_out_vld_i` in BUSY: flush wins and the result is not loaded.
- Simultaneous `flush_i` and `wb_ready_i` in RESP: the FSM goes to IDLE either way, and no duplicate writeback occurs.

## Configuration
- Macro: `DIV_ZERO_FASTPATH_EN`.
- Defined:
  - In IDLE, a request whose prepared `op_b` is zero does not raise `div_in_vld_o`.
  - The result register loads directly from the request: quotient all-ones, remainder = prepared `op_a`, then W formatting.
  - The FSM goes straight to RESP, so `valid_o` arrives the cycle after `valid_i`.
- Undefined: zero divisors go to the divider like any other request.

## Structure
- Shared package (ariane_pkg):
  - The fu_op enum values.
  - TRANS_ID_BITS.
  - The 2-bit divider opcode constants (DIV_OP_UDIV/DIV/UREM/REM).
  - The FSM state typedef.
- One combinational sub-module, `div_operand_prep`: W extension plus the opcode/flag decode. The FSM and registers stay in `div_issue_ctrl`.

## Test plan
- DIV, a=-7, b=2 (64-bit) -> `div_op_*` unchanged, `div_opcode_o=1`, `result_o=0xFFFFFFFFFFFFFFFD`, `trans_id_o` matches.
- DIVUW, a=0xFFFFFFFF_80000000, b=2 -> `div_op_a_o=0x0000000080000000`, `result_o=0x0000000040000000`.
- REMW, a=0x00000000_FFFFFFF9, b=0x2 -> `div_op_a_o=0xFFFFFFFFFFFFFFF9`, divider returns -1, `result_o=0xFFFFFFFFFFFFFFFF`.
- Flush in BUSY, then the divider returns a stale response -> `valid_o` stays 0, FSM is in IDLE, and the next DIVU 10/3 yields 3.
- `wb_ready_i=0` for 5 cycles in RESP -> `valid_o`, `result_o` and `trans_id_o` stable, `ready_o=0`. Release -> one writeback, then IDLE.
- With `DIV_ZERO_FASTPATH_EN`: REM a=5, b=0 -> `div_in_vld_o` never rises, `valid_o` the next cycle, `result_o=5`. DIVU a=5, b=0 -> `result_o` all-ones.
